// File: rtl/conv_tile_scheduler.sv
`timescale 1ns/1ps
// conv_tile_scheduler
// Layer-level controller in front of the tile convolution engine. It walks the
// tile loop nest of one convolution layer (m innermost, then n, col, row),
// presents each tile's base coordinates, and pulses a tile start. It waits for
// the engine's tile-done pulse and leaves a settle gap before the next tile.
// After the last tile it pulses conv_done.
//
// Ports:
//   clk             system clock
//   rst             asynchronous, active-high reset
//   conv_start      single-cycle layer start pulse (honoured only when idle)
//   conv_done       single-cycle layer completion pulse
//   busy            high from the cycle after an accepted start through conv_done
//   conv_tile_start single-cycle tile start pulse
//   conv_tile_done  single-cycle tile completion pulse (honoured only in WAIT)
//   tile_base_n/m/row/col  current tile base coordinates
//   tile_cnt        tiles completed in the current layer
module conv_tile_scheduler #(
  parameter int CW              = 16,
  parameter int N               = 32,
  parameter int M               = 32,
  parameter int R               = 64,
  parameter int C               = 32,
  parameter int Tn              = 16,
  parameter int Tm              = 16,
  parameter int Tr              = 64,
  parameter int Tc              = 16,
  parameter int TILE_ROW_OFFSET = 2,
  parameter int GAP             = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          conv_start,
  output logic          conv_done,
  output logic          busy,
  output logic          conv_tile_start,
  input  logic          conv_tile_done,
  output logic [CW-1:0] tile_base_n,
  output logic [CW-1:0] tile_base_m,
  output logic [CW-1:0] tile_base_row,
  output logic [CW-1:0] tile_base_col,
  output logic [CW-1:0] tile_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // One extra bit on the sums so base+step never wraps before the compare.
  localparam logic [CW:0] STEP_M  = (CW+1)'(Tm);
  localparam logic [CW:0] BOUND_M = (CW+1)'(M);
  localparam logic [CW:0] STEP_N  = (CW+1)'(Tn);
  localparam logic [CW:0] BOUND_N = (CW+1)'(N);
  localparam logic [CW:0] STEP_C  = (CW+1)'(Tc - TILE_ROW_OFFSET);
  localparam logic [CW:0] BOUND_C = (CW+1)'(C - TILE_ROW_OFFSET);
  localparam logic [CW:0] STEP_R  = (CW+1)'(Tr - TILE_ROW_OFFSET);
  localparam logic [CW:0] BOUND_R = (CW+1)'(R - TILE_ROW_OFFSET);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] n_q, n_d, m_q, m_d, row_q, row_d, col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d, gap_q, gap_d;
  logic          start_q, start_d, done_q, done_d, busy_q, busy_d;

  logic [CW:0]   m_sum, n_sum, c_sum, r_sum;
  logic          m_wrap, n_wrap, c_wrap, r_wrap, last_tile;
  logic [CW-1:0] m_nxt, n_nxt, c_nxt, r_nxt;

  // Next tile coordinates: an inner loop wrapping to 0 carries into the next
  // outer loop; the last tile is the one where every loop wraps.
  always_comb begin
    m_sum  = {1'b0, m_q}   + STEP_M;
    n_sum  = {1'b0, n_q}   + STEP_N;
    c_sum  = {1'b0, col_q} + STEP_C;
    r_sum  = {1'b0, row_q} + STEP_R;
    m_wrap = (m_sum >= BOUND_M);
    n_wrap = (n_sum >= BOUND_N);
    c_wrap = (c_sum >= BOUND_C);
    r_wrap = (r_sum >= BOUND_R);
    last_tile = m_wrap && n_wrap && c_wrap && r_wrap;
    m_nxt = m_wrap ? '0 : m_sum[CW-1:0];
    n_nxt = !m_wrap ? n_q : (n_wrap ? '0 : n_sum[CW-1:0]);
    c_nxt = !(m_wrap && n_wrap) ? col_q : (c_wrap ? '0 : c_sum[CW-1:0]);
    r_nxt = !(m_wrap && n_wrap && c_wrap) ? row_q : (r_wrap ? '0 : r_sum[CW-1:0]);
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (conv_start) begin
          state_d = S_ISSUE;
          n_d     = '0;
          m_d     = '0;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (conv_tile_done) begin
          cnt_d = cnt_q + CW'(1);
          if (last_tile) begin
            // Bases keep the last tile's values through DONE and IDLE.
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
            n_d     = n_nxt;
            m_d     = m_nxt;
            row_d   = r_nxt;
            col_d   = c_nxt;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_ISSUE;
          start_d = 1'b1;
        end else begin
          gap_d = gap_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      m_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign conv_done       = done_q;
  assign busy            = busy_q;
  assign conv_tile_start = start_q;
  assign tile_base_n     = n_q;
  assign tile_base_m     = m_q;
  assign tile_base_row   = row_q;
  assign tile_base_col   = col_q;
  assign tile_cnt        = cnt_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
`timescale 1ns/1ps
module tb_conv_tile_scheduler;

  localparam int CW  = 16;
  localparam int N   = 32, M = 32, R = 64, C = 32;
  localparam int Tn  = 16, Tm = 16, Tr = 64, Tc = 16;
  localparam int OFF = 2;
  localparam int GAP = 4;

  logic clk;
  logic rst;

  // default-parameter instance
  logic          conv_start, conv_done, busy, conv_tile_start, conv_tile_done;
  logic [CW-1:0] tile_base_n, tile_base_m, tile_base_row, tile_base_col, tile_cnt;

  // single-tile instance
  logic          s_start, s_done, s_busy, s_tstart, s_tdone;
  logic [CW-1:0] s_n, s_m, s_row, s_col, s_cnt;

  int errors = 0;
  int checks = 0;

  logic [CW-1:0] exp_row [64];
  logic [CW-1:0] exp_col [64];
  logic [CW-1:0] exp_n   [64];
  logic [CW-1:0] exp_m   [64];
  int NT;

  conv_tile_scheduler #(
    .CW(CW), .N(N), .M(M), .R(R), .C(C), .Tn(Tn), .Tm(Tm), .Tr(Tr), .Tc(Tc),
    .TILE_ROW_OFFSET(OFF), .GAP(GAP)
  ) u_dut (
    .clk(clk), .rst(rst), .conv_start(conv_start), .conv_done(conv_done),
    .busy(busy), .conv_tile_start(conv_tile_start), .conv_tile_done(conv_tile_done),
    .tile_base_n(tile_base_n), .tile_base_m(tile_base_m),
    .tile_base_row(tile_base_row), .tile_base_col(tile_base_col), .tile_cnt(tile_cnt)
  );

  conv_tile_scheduler #(
    .CW(CW), .N(16), .M(16), .R(64), .C(16), .Tn(16), .Tm(16), .Tr(64), .Tc(16),
    .TILE_ROW_OFFSET(OFF), .GAP(GAP)
  ) u_one (
    .clk(clk), .rst(rst), .conv_start(s_start), .conv_done(s_done),
    .busy(s_busy), .conv_tile_start(s_tstart), .conv_tile_done(s_tdone),
    .tile_base_n(s_n), .tile_base_m(s_m),
    .tile_base_row(s_row), .tile_base_col(s_col), .tile_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bases();
    return {tile_base_row, tile_base_col, tile_base_n, tile_base_m};
  endfunction

  function automatic logic [63:0] exp_bases(input int t);
    return {exp_row[t], exp_col[t], exp_n[t], exp_m[t]};
  endfunction

  task automatic start_layer();
    chk("idle_busy", 64'(busy), 64'd0);
    conv_start = 1'b1;
    @(negedge clk);
    conv_start = 1'b0;
  endtask

  // Entered at the negedge of the cycle where tile t's start must be high.
  // Leaves at the negedge where tile t+1's start must be high, or after
  // the conv_done cycle for the last tile.
  task automatic run_tile(input int t, input int dly, input bit inj);
    bit ok;
    chk("tile_start", 64'(conv_tile_start), 64'd1);
    chk("tile_busy", 64'(busy), 64'd1);
    chk("tile_bases", bases(), exp_bases(t));
    chk("tile_cnt_at_issue", 64'(tile_cnt), 64'(t));
    ok = 1'b1;
    if (inj) begin
      // done coincident with the start pulse must be ignored
      conv_tile_done = 1'b1;
      @(negedge clk);
      conv_tile_done = 1'b0;
      chk("done_with_start_cnt", 64'(tile_cnt), 64'(t));
    end
    for (int i = 0; i < dly; i++) begin
      conv_start = (inj && i == 1);
      @(negedge clk);
      conv_start = 1'b0;
      if (conv_tile_start !== 1'b0 || busy !== 1'b1 || conv_done !== 1'b0 ||
          bases() !== exp_bases(t)) ok = 1'b0;
    end
    chk("wait_stable", 64'(ok), 64'd1);
    conv_tile_done = 1'b1;
    @(negedge clk);
    conv_tile_done = 1'b0;
    if (t == NT - 1) begin
      chk("conv_done_pulse", 64'(conv_done), 64'd1);
      chk("final_cnt", 64'(tile_cnt), 64'(NT));
      chk("busy_at_done", 64'(busy), 64'd1);
      @(negedge clk);
      chk("conv_done_single", 64'(conv_done), 64'd0);
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("bases_hold", bases(), exp_bases(t));
      chk("cnt_hold", 64'(tile_cnt), 64'(NT));
    end else begin
      chk("gap_bases_adv", bases(), exp_bases(t + 1));
      ok = 1'b1;
      for (int i = 0; i < GAP; i++) begin
        if (conv_tile_start !== 1'b0 || busy !== 1'b1 || conv_done !== 1'b0) ok = 1'b0;
        conv_tile_done = (inj && i == 1);
        conv_start     = (inj && i == 2);
        @(negedge clk);
        conv_tile_done = 1'b0;
        conv_start     = 1'b0;
      end
      chk("gap_quiet", 64'(ok), 64'd1);
      chk("gap_cnt", 64'(tile_cnt), 64'(t + 1));
    end
  endtask

  initial begin
    bit ok;
    // reference tile order: row outermost, m innermost
    NT = 0;
    for (int r = 0; r < R - OFF; r += Tr - OFF)
      for (int c = 0; c < C - OFF; c += Tc - OFF)
        for (int n = 0; n < N; n += Tn)
          for (int m = 0; m < M; m += Tm) begin
            exp_row[NT] = CW'(r);
            exp_col[NT] = CW'(c);
            exp_n[NT]   = CW'(n);
            exp_m[NT]   = CW'(m);
            NT++;
          end

    rst = 1'b1;
    conv_start = 1'b0;
    conv_tile_done = 1'b0;
    s_start = 1'b0;
    s_tdone = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {bases(), 8'(tile_cnt), conv_done, busy, conv_tile_start},
        64'd0);

    // conv_start together with reset: reset wins
    conv_start = 1'b1;
    @(negedge clk);
    conv_start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wins_start", 64'(conv_tile_start), 64'd0);
    chk("rst_wins_busy", 64'(busy), 64'd0);

    // layer A: fixed 10-cycle tile response
    start_layer();
    for (int t = 0; t < NT; t++) run_tile(t, 10, 1'b0);

    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (conv_tile_start !== 1'b0 || busy !== 1'b0 || conv_done !== 1'b0) ok = 1'b0;
    end
    chk("idle_after_layer", 64'(ok), 64'd1);

    // layer B: random response delays with spurious starts and dones
    start_layer();
    for (int t = 0; t < NT; t++) run_tile(t, int'($urandom_range(2, 15)), 1'b1);

    // layer C: asynchronous reset during WAIT of the fifth tile
    start_layer();
    for (int t = 0; t < 4; t++) run_tile(t, int'($urandom_range(1, 12)), 1'b0);
    chk("t5_start", 64'(conv_tile_start), 64'd1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {bases(), 8'(tile_cnt), conv_done, busy, conv_tile_start},
        64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("no_done_after_rst", 64'(conv_done), 64'd0);
    chk("idle_after_rst", 64'(busy), 64'd0);

    // layer D: restart from origin, first tile's done held off 1000 cycles
    start_layer();
    run_tile(0, 1000, 1'b0);
    for (int t = 1; t < NT; t++) run_tile(t, int'($urandom_range(1, 9)), 1'b0);

    // single-tile configuration
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("one_start", 64'(s_tstart), 64'd1);
    chk("one_bases", {s_row, s_col, s_n, s_m}, 64'd0);
    repeat (3) @(negedge clk);
    s_tdone = 1'b1;
    @(negedge clk);
    s_tdone = 1'b0;
    chk("one_done", 64'(s_done), 64'd1);
    chk("one_cnt", 64'(s_cnt), 64'd1);
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (s_tstart !== 1'b0 || s_done !== 1'b0 || s_busy !== 1'b0) ok = 1'b0;
    end
    chk("one_no_gap", 64'(ok), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
